// File: rtl/nla_pkg.sv
// rtl/nla_pkg.sv - shared FSM type and constants for the Horner sequencer
package nla_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   localparam logic [2:0] FN_SELU    = 3'd0;
   localparam logic [2:0] FN_SIGMOID = 3'd1;
   localparam logic [2:0] FN_SWISH   = 3'd2;
   localparam logic [2:0] FN_GELU    = 3'd3;
   localparam logic [2:0] FN_TANH    = 3'd4;

   localparam logic [31:0] FP_NAN = 32'h7F900000;

endpackage

// File: rtl/nla_coeff_ram.sv
// rtl/nla_coeff_ram.sv - coefficient storage, one write port, one synchronous read port
module nla_coeff_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_LINES = 5
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_LINES-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_LINES-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_LINES];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read data holds while re_i is low so a stalled prefetch is not lost.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/nla_horner_sequencer.sv
// rtl/nla_horner_sequencer.sv - streams (sample, coefficient) pairs to the MAC in Horner order
module nla_horner_sequencer
   import nla_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_LINES = 5,
   parameter int FUNC_W     = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cfg_we_i,
   input  logic [ADDR_LINES-1:0] cfg_addr_i,
   input  logic [DATA_WIDTH-1:0] cfg_data_i,
   input  logic                  desc_we_i,
   input  logic [FUNC_W-1:0]     desc_sel_i,
   input  logic [ADDR_LINES-1:0] desc_base_i,
   input  logic [ADDR_LINES-1:0] desc_deg_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [FUNC_W-1:0]     req_func_i,
   input  logic [DATA_WIDTH-1:0] req_x_i,
   output logic [DATA_WIDTH-1:0] signal_o,
   output logic [DATA_WIDTH-1:0] coeff_o,
   output logic                  mac_valid_o,
   output logic                  mac_first_o,
   output logic                  mac_last_o,
   input  logic                  mac_full_i,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam int NFUNC = 1 << FUNC_W;
   localparam logic [ADDR_LINES-1:0] ADDR_ONE = 1;

   state_e                state_q;
   logic [NFUNC-1:0]      desc_vld_q;
   logic [ADDR_LINES-1:0] desc_base_q [NFUNC];
   logic [ADDR_LINES-1:0] desc_deg_q  [NFUNC];
   logic [DATA_WIDTH-1:0] x_q, sig_q, coeff_q;
   logic [ADDR_LINES-1:0] ptr_q, cnt_q;
   logic                  pend_q, first_q, last_q, err_q;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  slot_free, ram_re, ram_we;

   // The output slot frees up when empty or when the MAC takes the pending pair.
   assign slot_free = !pend_q || !mac_full_i;
   assign ram_re    = (state_q == ST_FETCH) || ((state_q == ST_ISSUE) && slot_free);
   assign ram_we    = cfg_we_i && (state_q == ST_IDLE);

   nla_coeff_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_LINES(ADDR_LINES)
   ) u_ram (
      .clk_i  (clk_i),
      .we_i   (ram_we),
      .waddr_i(cfg_addr_i),
      .wdata_i(cfg_data_i),
      .re_i   (ram_re),
      .raddr_i(ptr_q),
      .rdata_o(ram_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         desc_vld_q <= '0;
         for (int i = 0; i < NFUNC; i++) begin
            desc_base_q[i] <= '0;
            desc_deg_q[i]  <= '0;
         end
         x_q     <= '0;
         sig_q   <= '0;
         coeff_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (desc_we_i) begin
            if (state_q == ST_IDLE) begin
               desc_vld_q[desc_sel_i]  <= 1'b1;
               desc_base_q[desc_sel_i] <= desc_base_i;
               desc_deg_q[desc_sel_i]  <= desc_deg_i;
            end else begin
               err_q <= 1'b1;
            end
         end
         if (cfg_we_i && (state_q != ST_IDLE)) err_q <= 1'b1;

         case (state_q)
            ST_IDLE: begin
               // Descriptor regs are read before this edge's write, so a same-cycle update is not seen.
               if (req_valid_i) begin
                  if (desc_vld_q[req_func_i]) begin
                     x_q     <= req_x_i;
                     ptr_q   <= desc_base_q[req_func_i] + desc_deg_q[req_func_i];
                     cnt_q   <= desc_deg_q[req_func_i];
                     state_q <= ST_FETCH;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               ptr_q   <= ptr_q - ADDR_ONE;
               state_q <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (slot_free) begin
                  if (pend_q && last_q) begin
                     pend_q  <= 1'b0;
                     first_q <= 1'b0;
                     last_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     pend_q  <= 1'b1;
                     coeff_q <= ram_rdata;
                     sig_q   <= x_q;
                     first_q <= !pend_q;
                     last_q  <= (cnt_q == '0);
                     cnt_q   <= cnt_q - ADDR_ONE;
                     ptr_q   <= ptr_q - ADDR_ONE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mac_valid_o = pend_q && !mac_full_i;
   assign mac_first_o = first_q && mac_valid_o;
   assign mac_last_o  = last_q && mac_valid_o;
   assign signal_o    = sig_q;
   assign coeff_o     = coeff_q;
   assign req_ready_o = (state_q == ST_IDLE);
   assign busy_o      = (state_q != ST_IDLE);
   assign err_o       = err_q;

endmodule

// File: tb/tb_nla_horner_sequencer.sv
// tb/tb_nla_horner_sequencer.sv - directed bench for the Horner sequencer
module tb_nla_horner_sequencer;
   import nla_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        desc_we;
   logic [2:0]  desc_sel;
   logic [4:0]  desc_base, desc_deg;
   logic        req_valid, req_ready;
   logic [2:0]  req_func;
   logic [31:0] req_x;
   logic [31:0] signal_w, coeff_w;
   logic        mac_valid, mac_first, mac_last, mac_full, busy, err;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   nla_horner_sequencer #(.DATA_WIDTH(32), .ADDR_LINES(5), .FUNC_W(3)) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
      .desc_we_i(desc_we), .desc_sel_i(desc_sel), .desc_base_i(desc_base), .desc_deg_i(desc_deg),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_func_i(req_func), .req_x_i(req_x),
      .signal_o(signal_w), .coeff_o(coeff_w),
      .mac_valid_o(mac_valid), .mac_first_o(mac_first), .mac_last_o(mac_last),
      .mac_full_i(mac_full), .busy_o(busy), .err_o(err)
   );

   function automatic logic [31:0] coef(input int a);
      if (a == 0)  return 32'h3F800000;
      if (a == 30) return 32'h189C9963;
      return 32'h3E000000 | 32'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_coef(input int a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic wr_desc(input logic [2:0] sel, input int base, input int deg);
      desc_we = 1'b1; desc_sel = sel; desc_base = 5'(base); desc_deg = 5'(deg);
      step();
      desc_we = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 60) begin
         step();
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(req_ready), 32'd1);
      step();
   endtask

   // Cycle j is the cycle after acceptance edge T+j; stall[j] drives mac_full_i in that cycle.
   task automatic eval(input logic [2:0] fn, input logic [31:0] x, input int base, input int deg,
                       input logic [63:0] stall, output int pairs, output int first_cyc,
                       output int done_cyc);
      req_valid = 1'b1; req_func = fn; req_x = x;
      step();
      req_valid = 1'b0;
      pairs = 0; first_cyc = -1; done_cyc = -1;
      for (int j = 0; j < 64 && done_cyc < 0; j++) begin
         mac_full = stall[j];
         @(negedge clk);
         if (req_ready) done_cyc = j;
         if (mac_valid) begin
            if (pairs == 0) first_cyc = j;
            chk("coeff", coeff_w, coef((base + deg - pairs) & 31));
            chk("signal", signal_w, x);
            chk("first", 32'(mac_first), 32'(pairs == 0));
            chk("last", 32'(mac_last), 32'(pairs == deg));
            pairs++;
         end
         step();
      end
      mac_full = 1'b0;
   endtask

   int pairs, fc, dc;

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      desc_we = 1'b0; desc_sel = '0; desc_base = '0; desc_deg = '0;
      req_valid = 1'b0; req_func = '0; req_x = '0; mac_full = 1'b0;
      step(); step();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(mac_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_coeff", coeff_w, 32'd0);
      chk("rst_signal", signal_w, 32'd0);
      rst = 1'b0;
      step();

      // Unprogrammed function 7: request is consumed with an error pulse only.
      req_valid = 1'b1; req_func = 3'd7; req_x = 32'h12345678;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("inv_err", 32'(err), 32'd1);
      chk("inv_ready", 32'(req_ready), 32'd1);
      chk("inv_valid", 32'(mac_valid), 32'd0);
      step();
      @(negedge clk);
      chk("inv_err_clr", 32'(err), 32'd0);
      chk("inv_valid2", 32'(mac_valid), 32'd0);
      step();

      for (int a = 0; a < 32; a++) wr_coef(a, coef(a));
      wr_desc(FN_TANH, 0, 30);
      wr_desc(FN_SIGMOID, 28, 6);
      wr_desc(FN_SWISH, 5, 0);

      eval(FN_TANH, 32'h40A00000, 0, 30, 64'd0, pairs, fc, dc);
      chk("tanh_pairs", 32'(pairs), 32'd31);
      chk("tanh_first_cyc", 32'(fc), 32'd2);
      chk("tanh_done", 32'(dc), 32'd33);

      eval(FN_TANH, 32'h40A00000, 0, 30, (64'h7 << 10) | (64'h1 << 15) | (64'h1 << 18), pairs, fc, dc);
      chk("stall_pairs", 32'(pairs), 32'd31);
      chk("stall_done", 32'(dc), 32'd38);

      eval(FN_SIGMOID, 32'h3F000000, 28, 6, 64'd0, pairs, fc, dc);
      chk("wrap_pairs", 32'(pairs), 32'd7);
      chk("wrap_done", 32'(dc), 32'd9);

      eval(FN_SWISH, 32'hC0000000, 5, 0, 64'd0, pairs, fc, dc);
      chk("deg0_pairs", 32'(pairs), 32'd1);
      chk("deg0_first_cyc", 32'(fc), 32'd2);
      chk("deg0_done", 32'(dc), 32'd3);

      // Coefficient write during ISSUE must be dropped and flagged.
      req_valid = 1'b1; req_func = FN_SIGMOID; req_x = 32'h3F000000;
      step();
      req_valid = 1'b0;
      step(); step();
      cfg_we = 1'b1; cfg_addr = 5'd29; cfg_data = 32'hDEADBEEF;
      step();
      cfg_we = 1'b0;
      @(negedge clk);
      chk("cfg_busy_err", 32'(err), 32'd1);
      chk("cfg_busy_busy", 32'(busy), 32'd1);
      step();
      wait_idle("cfg_busy_drain");
      eval(FN_SIGMOID, 32'h3F000000, 28, 6, 64'd0, pairs, fc, dc);
      chk("cfg_busy_pairs", 32'(pairs), 32'd7);

      // Reset mid-ISSUE aborts at once and clears descriptors.
      req_valid = 1'b1; req_func = FN_TANH; req_x = 32'h40A00000;
      step();
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) step();
      rst = 1'b1;
      #1;
      chk("rstmid_ready", 32'(req_ready), 32'd1);
      chk("rstmid_valid", 32'(mac_valid), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_coeff", coeff_w, 32'd0);
      step();
      rst = 1'b0;
      step();
      req_valid = 1'b1; req_func = FN_TANH;
      step();
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid_desc_err", 32'(err), 32'd1);
      chk("rstmid_desc_ready", 32'(req_ready), 32'd1);
      chk("rstmid_desc_valid", 32'(mac_valid), 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/nla_horner_sequencer.md
Name: nla_horner_sequencer

Overview:
Scheduler in front of the floating-point MAC. It takes one input sample plus a function ID, looks up that function's coefficient block in a local RAM, and streams (sample, coefficient) pairs to the MAC in Horner order, highest degree first. It respects MAC back-pressure and frames each evaluation with first/last markers. Software loads coefficients and per-function descriptors (base, degree) through a config port while the block is idle.

Parameters:
DATA_WIDTH, 32, width of samples and coefficients (IEEE-754 single)
ADDR_LINES, 5, coefficient RAM address width (2^ADDR_LINES entries)
FUNC_W, 3, function-ID width (2^FUNC_W descriptors)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
cfg_we_i  in  1  coefficient RAM write strobe
cfg_addr_i  in  ADDR_LINES  coefficient RAM write address
cfg_data_i  in  DATA_WIDTH  coefficient value
desc_we_i  in  1  descriptor write strobe
desc_sel_i  in  FUNC_W  descriptor index
desc_base_i  in  ADDR_LINES  RAM address of the degree-0 coefficient
desc_deg_i  in  ADDR_LINES  polynomial degree (terms = deg+1)
req_valid_i  in  1  evaluation request valid
req_ready_o  out  1  sequencer can accept a request
req_func_i  in  FUNC_W  function ID
req_x_i  in  DATA_WIDTH  input sample
signal_o  out  DATA_WIDTH  sample presented to MAC signal path
coeff_o  out  DATA_WIDTH  coefficient presented to MAC coeff path
mac_valid_o  out  1  pair valid this cycle
mac_first_o  out  1  first term of an evaluation (highest degree)
mac_last_o  out  1  last term (degree 0)
mac_full_i  in  1  MAC input FIFOs full: stall
busy_o  out  1  evaluation in progress
err_o  out  1  one-cycle error pulse

Behaviour:
- Reset: all outputs 0 except req_ready_o=1. FSM goes to IDLE and all descriptor valid bits clear. RAM contents are not reset.
- FSM IDLE -> FETCH -> ISSUE -> IDLE. req_ready_o = (state==IDLE). busy_o = (state!=IDLE).
- Accept on req_valid_i & req_ready_o at edge T. Latch req_x_i, base, deg; set ptr = base+deg (mod 2^ADDR_LINES); term count = deg.
- FETCH, T+1: RAM read of ptr issued. The RAM is synchronous-read, 1-cycle latency.
- ISSUE: first pair at T+2 with mac_first_o=1. Absent stall, one pair per cycle. ptr decrements with wrap mod 2^ADDR_LINES. mac_last_o=1 on the deg-0 term (address base).
  - deg=0: a single pair with first=last=1.
- After the last pair the FSM returns to IDLE; req_ready_o=1 at T+3+deg with no stalls.
- Stall: in any cycle with mac_full_i=1, mac_valid_o=0 and ptr, count and outputs hold. Resume with the same pending term; no term is dropped or duplicated. The RAM prefetch is held or replayed as needed. mac_full_i is sampled combinationally in the same cycle.
- signal_o is constant (latched sample) for the whole evaluation. coeff_o and signal_o hold their last values when mac_valid_o=0.
- Request for a function whose descriptor is invalid: request consumed, no pairs issued, err_o pulses at T+1, FSM stays IDLE.
- cfg_we_i or desc_we_i while busy_o=1: write ignored, err_o pulses next cycle.
- cfg_we_i or desc_we_i while idle: write takes effect at the edge. desc_we_i sets that descriptor's valid bit.
- Request accepted in the same cycle as a desc write to the same index: the old descriptor is used.
- Reset mid-evaluation: immediate abort, no further pairs, and descriptors must be reloaded.

Decomposition:
- Shared package nla_pkg:
  - FSM state enum (IDLE, FETCH, ISSUE)
  - function-ID constants: FN_SELU=0, FN_SIGMOID=1, FN_SWISH=2, FN_GELU=3, FN_TANH=4
  - FP_NAN constant 32'h7F900000
- One sub-module, nla_coeff_ram: 2^ADDR_LINES x DATA_WIDTH, one write port, one synchronous read port.
- The descriptor file and FSM stay in the top.

Test Plan:
- Load TanH coefficients 0..30 at addresses 0..30, desc(4)={base 0, deg 30}, request x=32'h40A00000 with no stall.
  - 31 pairs on consecutive cycles starting T+2.
  - coeff_o: addr 30 (32'h189C9963) first with first=1, ..., addr 0 (32'h3F800000) last with last=1.
  - signal_o=32'h40A00000 throughout; req_ready_o returns at T+33.
- Same as above with mac_full_i high for 3 cycles mid-stream, then 1 cycle twice.
  - Exactly 31 valid pairs, in order, no duplicates.
  - Completion delayed by exactly 5 cycles.
- desc={base 28, deg 6}: coefficients read from addresses 2,1,0,31,30,29,28 (wrap); last=1 on addr 28.
- deg=0 descriptor: a single pair at T+2 with first=last=1; ready again at T+3.
- Request func 7 after reset (never programmed): err_o=1 at T+1, no mac_valid_o, ready stays 1.
- cfg_we_i during ISSUE: RAM unchanged (readback in a later request shows the old value) and err_o pulses.
- Assert rst_i mid-ISSUE: outputs go to 0 and req_ready_o goes to 1 at once. A following request to func 4 errors (descriptor cleared).
